// File: rtl/tt06_pwm_multi_if.sv
// Register-write bus and PWM output bundle for tt06_pwm_multi.
interface tt06_pwm_multi_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(NCH + 2)
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NCH-1:0]   pwm_out;
  logic [NCH-1:0]   pwm_out_d;
  logic             period_tick;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  pwm_out, pwm_out_d, period_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output pwm_out, pwm_out_d, period_tick
  );
endinterface

// File: rtl/tt06_pwm_multi.sv
// Multi-channel PWM generator with shadowed duty/period/mode registers,
// edge-aligned or center-aligned counting, and a period boundary tick.
module tt06_pwm_multi #(
  parameter int NCH          = 4,
  parameter int WIDTH        = 8,
  parameter int RESET_PERIOD = 2**WIDTH - 1
) (
  input logic             clk,
  input logic             reset,
  tt06_pwm_multi_if.slave bus
);
  localparam int AW = $clog2(NCH + 2);
  localparam logic [WIDTH-1:0] RST_PER   = WIDTH'(RESET_PERIOD);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [AW-1:0]    ADDR_PER  = AW'(NCH);
  localparam logic [AW-1:0]    ADDR_CTRL = AW'(NCH + 1);

  logic [WIDTH-1:0] duty_pend     [NCH];
  logic [WIDTH-1:0] duty_act      [NCH];
  logic [WIDTH-1:0] duty_pend_nxt [NCH];
  logic [WIDTH-1:0] per_pend, per_act, per_pend_nxt;
  logic             mode_pend, mode_act, mode_pend_nxt;
  logic             en, en_nxt, ctrl_wr, run, copy;
  logic [WIDTH-1:0] cnt_p0, cnt_nxt;
  logic             down_p0, down_nxt, boundary;
  logic [NCH-1:0]   pwm_p1, pwm_p2;
  logic             tick_p1;

  assign ctrl_wr = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
  // Count only once enable is established and not being cleared this cycle,
  // so the first counting cycle already sees the freshly copied active set.
  assign run  = en && en_nxt;
  // Shadow copy happens every cycle while idle and at every period boundary.
  assign copy = !en || boundary;

  // Pending values as they stand after this cycle's write (write-through source)
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      duty_pend_nxt[i] = (bus.wr_en && (bus.wr_addr == AW'(i))) ? bus.wr_data : duty_pend[i];
    end
    per_pend_nxt  = (bus.wr_en && (bus.wr_addr == ADDR_PER)) ? bus.wr_data : per_pend;
    mode_pend_nxt = ctrl_wr ? bus.wr_data[1] : mode_pend;
    en_nxt        = ctrl_wr ? bus.wr_data[0] : en;
  end

  // Next counter value and direction; the boundary is the cycle whose successor is cnt=0
  always_comb begin
    cnt_nxt  = '0;
    down_nxt = 1'b0;
    if (!mode_act) begin
      cnt_nxt = (cnt_p0 >= per_act) ? '0 : cnt_p0 + ONE;
    end else if (per_act == '0) begin
      cnt_nxt = '0;
    end else if (down_p0 || (cnt_p0 >= per_act)) begin
      cnt_nxt  = cnt_p0 - ONE;
      down_nxt = (cnt_nxt != '0);
    end else begin
      cnt_nxt = cnt_p0 + ONE;
    end
    boundary = (cnt_nxt == '0);
  end

  // Register file: pending registers, active shadows and the enable bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        duty_pend[i] <= '0;
        duty_act[i]  <= '0;
      end
      per_pend  <= RST_PER;
      per_act   <= RST_PER;
      mode_pend <= 1'b0;
      mode_act  <= 1'b0;
      en        <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        duty_pend[i] <= duty_pend_nxt[i];
        if (copy) duty_act[i] <= duty_pend_nxt[i];
      end
      per_pend  <= per_pend_nxt;
      mode_pend <= mode_pend_nxt;
      en        <= en_nxt;
      if (copy) begin
        per_act  <= per_pend_nxt;
        mode_act <= mode_pend_nxt;
      end
    end
  end

  // Stage p0: period counter, parked at zero counting up whenever not running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p0  <= '0;
      down_p0 <= 1'b0;
    end else if (run) begin
      cnt_p0  <= cnt_nxt;
      down_p0 <= down_nxt;
    end else begin
      cnt_p0  <= '0;
      down_p0 <= 1'b0;
    end
  end

  // Stage p1: duty compare and boundary tick, both reflecting the p0 count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_p1  <= '0;
      tick_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pwm_p1[i] <= run && (cnt_p0 < duty_act[i]);
      end
      tick_p1 <= run && boundary;
    end
  end

  // Stage p2: one-clock delayed copy of the PWM outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_p2 <= '0;
    end else begin
      pwm_p2 <= pwm_p1;
    end
  end

  assign bus.pwm_out     = pwm_p1;
  assign bus.pwm_out_d   = pwm_p2;
  assign bus.period_tick = tick_p1;
endmodule

// File: doc/tt06_pwm_multi.md
TT06_PWM_MULTI -- requirements
Module: tt06_pwm_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of PWM channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, counter/duty/period width in bits (4..16).
REQ-003 SHALL have parameter RESET_PERIOD, default 2**WIDTH-1, period value loaded at reset.
REQ-004 SHALL define localparam AW = $clog2(NCH+2), the register address width.
REQ-005 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port: reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: wr_en  input  1  register write strobe, one write per cycle.
REQ-008 SHALL have port: wr_addr  input  AW  register address.
REQ-009 SHALL have port: wr_data  input  WIDTH  register write data.
REQ-010 SHALL have port: pwm_out  output  NCH  registered PWM outputs.
REQ-011 SHALL have port: pwm_out_d  output  NCH  pwm_out delayed one clock.
REQ-012 SHALL have port: period_tick  output  1  one-cycle pulse per PWM period boundary.

Function
REQ-013 SHALL use register map: addr 0..NCH-1 = duty[i] pending; NCH = period pending; NCH+1 = ctrl (bit0 enable, bit1 mode: 0 edge-aligned, 1 center-aligned; upper bits ignored); other addresses ignored.
REQ-014 SHALL hold pending and active copies of every duty, period and mode; enable has no shadow and acts on the next clock.
REQ-015 SHALL copy all pending values to active in every boundary cycle; a write in that same cycle is included (write-through).
REQ-016 SHALL copy pending to active in every cycle while enable=0.
REQ-017 Edge mode SHALL count cnt 0,1..P (P = active period), then wrap to 0; period = P+1 cycles; boundary cycle = cnt==P.
REQ-018 Center mode SHALL count 0 up to P, then P-1 down to 1, then 0; period = 2P cycles.
REQ-019 Center mode boundary cycle SHALL be cnt==1 while counting down; direction flips to down at cnt==P and to up at cnt==0.
REQ-020 With P==0 in either mode, cnt SHALL stay 0 and every cycle SHALL be a boundary.
REQ-021 SHALL register pwm_out[i] <= (cnt < active duty[i]) one clock after the cnt value it reflects; comparison unsigned WIDTH-bit.
REQ-022 Duty 0 SHALL give constant low; duty > P SHALL give constant high, with no glitch cycles.
REQ-023 Center mode, duty d<=P SHALL give 2d-1 high cycles of 2P, symmetric about cnt==0.
REQ-024 SHALL pulse period_tick for one cycle, registered, the cycle after each boundary cycle, and only while enable=1.
REQ-025 On enable 1->0, next clock SHALL force cnt=0, direction up, pwm_out=0, period_tick=0; pwm_out_d follows one cycle later.
REQ-026 On enable 0->1, counting SHALL start from cnt=0 with the values just copied to active.
REQ-027 A period write to a value below the current cnt SHALL NOT take effect until the boundary, so the counter never overruns.

Reset
REQ-028 Reset SHALL set cnt=0, direction up, all duty pending/active=0, period pending/active=RESET_PERIOD, enable=0, mode=0.
REQ-029 Reset SHALL set pwm_out=0, pwm_out_d=0, period_tick=0, asynchronously on assertion; reset mid-period SHALL discard all state.

Verification (NCH=4, WIDTH=8)
REQ-030 Reset: assert reset mid-operation with duty0=5 -> all outputs 0 immediately; after release with enable=0, outputs stay 0.
REQ-031 Edge: period=9, duty0=3, duty1=0, duty2=10, enable=1 -> pwm_out[0] 3 high / 7 low repeating; [1] constant 0; [2] constant 1; period_tick every 10 cycles; pwm_out_d equals pwm_out one cycle late.
REQ-032 Shadow: in edge P=9 with duty0=3, write duty0=7 at cnt=4 -> rest of the current period follows 3; the next period has 7 high cycles; no extra edge.
REQ-033 Center: period=4, mode=1, duty0=2 -> cnt 0,1,2,3,4,3,2,1 and pwm_out[0] pattern 1,1,0,0,0,0,0,1 (3 of 8); period_tick every 8 cycles.
REQ-034 Disable: enable 1->0 while pwm_out[0]=1 -> pwm_out[0]=0 next cycle; re-enable -> cnt restarts at 0 and the first period is full length.
REQ-035 Boundary write: write duty0=6 in the exact boundary cycle -> the very next period uses 6; write to addr 7 -> no state change.
